// File: rtl/mii_gen_pkg.sv
// Shared types and constants for the MII receive-path generator.
package mii_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    FCS,
    UNDER,
    IFG
  } state_t;

  localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
  localparam logic [31:0] CRC32_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

endpackage

// File: rtl/mii_phy_rx_gen_crc32_byte.sv
// Combinational byte-wide step of the reflected Ethernet CRC-32.
module crc32_byte
  import mii_gen_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/mii_phy_rx_gen.sv
// PHY-side MII receive generator: AXI-stream bytes -> preamble/SFD/data nibbles + IFG.
// Define MII_PHY_RX_GEN_FCS_EN to append a generated CRC-32 FCS after the data.
module mii_phy_rx_gen
  import mii_gen_pkg::*;
#(
  parameter int PREAMBLE_NIBBLES = 15,
  parameter int IFG_NIBBLES      = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [3:0] mii_rxd,
  output logic       mii_rx_dv,
  output logic       mii_rx_er,
  output logic       start_packet,
  output logic       error_underflow
);

  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_NIBBLES - 1);
  localparam logic [7:0] IFG_LAST = 8'(IFG_NIBBLES - 1);

  state_t     state_reg, state_next;
  logic [3:0] pre_cnt_reg, pre_cnt_next;
  logic [7:0] ifg_cnt_reg, ifg_cnt_next;
  logic [7:0] byte_reg, byte_next;
  logic       last_reg, last_next;
  logic       user_reg, user_next;
  logic       nib_reg, nib_next;
  logic       drain_reg, drain_next;
  logic [3:0] rxd_next;
  logic       dv_next, er_next, sp_next, uf_next;
  logic       handshake;

`ifdef MII_PHY_RX_GEN_FCS_EN
  logic [31:0] crc_reg, crc_next, crc_step;
  logic [2:0]  fcs_cnt_reg, fcs_cnt_next;
  logic [31:0] fcs_word;

  crc32_byte u_crc (
    .crc_in  (crc_reg),
    .data    (s_axis_tdata),
    .crc_out (crc_step)
  );
`endif

  always_comb begin
    s_axis_tready = 1'b0;
    if (rst_n) begin
      case (state_reg)
        SFD:     s_axis_tready = 1'b1;
        DATA:    s_axis_tready = nib_reg & ~last_reg;
        UNDER:   s_axis_tready = drain_reg;
        default: s_axis_tready = 1'b0;
      endcase
    end
  end

  assign handshake = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_next   = state_reg;
    pre_cnt_next = pre_cnt_reg;
    ifg_cnt_next = ifg_cnt_reg;
    byte_next    = byte_reg;
    last_next    = last_reg;
    user_next    = user_reg;
    nib_next     = nib_reg;
    drain_next   = drain_reg;
`ifdef MII_PHY_RX_GEN_FCS_EN
    crc_next     = crc_reg;
    fcs_cnt_next = fcs_cnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        last_next = 1'b0;
        if (s_axis_tvalid) begin
          state_next   = PRE;
          pre_cnt_next = 4'd0;
        end
      end
      PRE: begin
        last_next = 1'b0;
        if (pre_cnt_reg == PRE_LAST) state_next = SFD;
        else                         pre_cnt_next = pre_cnt_reg + 4'd1;
      end
      SFD: begin
        if (handshake) begin
          byte_next  = s_axis_tdata;
          last_next  = s_axis_tlast;
          user_next  = s_axis_tuser;
          nib_next   = 1'b0;
          state_next = DATA;
`ifdef MII_PHY_RX_GEN_FCS_EN
          crc_next   = crc_step;
`endif
        end else begin
          state_next = UNDER;
          drain_next = 1'b0;
        end
      end
      DATA: begin
        if (!nib_reg) begin
          nib_next = 1'b1;
        end else if (last_reg) begin
`ifdef MII_PHY_RX_GEN_FCS_EN
          state_next   = FCS;
          fcs_cnt_next = 3'd0;
`else
          state_next   = IFG;
          ifg_cnt_next = 8'd0;
`endif
        end else if (handshake) begin
          byte_next = s_axis_tdata;
          last_next = s_axis_tlast;
          user_next = s_axis_tuser;
          nib_next  = 1'b0;
`ifdef MII_PHY_RX_GEN_FCS_EN
          crc_next  = crc_step;
`endif
        end else begin
          state_next = UNDER;
          drain_next = 1'b0;
        end
      end
`ifdef MII_PHY_RX_GEN_FCS_EN
      FCS: begin
        if (fcs_cnt_reg == 3'd7) begin
          state_next   = IFG;
          ifg_cnt_next = 8'd0;
        end else begin
          fcs_cnt_next = fcs_cnt_reg + 3'd1;
        end
      end
`endif
      UNDER: begin
        if (!drain_reg) begin
          if (last_reg) begin
            state_next   = IFG;
            ifg_cnt_next = 8'd0;
          end else begin
            drain_next = 1'b1;
          end
        end else if (handshake && s_axis_tlast) begin
          state_next   = IFG;
          ifg_cnt_next = 8'd0;
        end
      end
      IFG: begin
        // Pending frames start straight from the last gap cycle so back-to-back
        // traffic sees exactly IFG_NIBBLES idle cycles.
        if (ifg_cnt_reg >= IFG_LAST) begin
          state_next   = s_axis_tvalid ? PRE : IDLE;
          pre_cnt_next = 4'd0;
        end else begin
          ifg_cnt_next = ifg_cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase

`ifdef MII_PHY_RX_GEN_FCS_EN
    if (state_reg == IDLE || state_reg == UNDER || state_reg == IFG) crc_next = CRC32_INIT;
    fcs_word = ~crc_next;
`endif

    // Outputs are registered, so they are decoded from the state being entered.
    rxd_next = 4'h0;
    dv_next  = 1'b0;
    er_next  = 1'b0;
    sp_next  = 1'b0;
    uf_next  = 1'b0;
    case (state_next)
      PRE: begin
        dv_next  = 1'b1;
        rxd_next = PREAMBLE_NIBBLE;
        sp_next  = (state_reg != PRE);
      end
      SFD: begin
        dv_next  = 1'b1;
        rxd_next = SFD_NIBBLE;
      end
      DATA: begin
        dv_next  = 1'b1;
        rxd_next = nib_next ? byte_next[7:4] : byte_next[3:0];
        er_next  = user_next;
      end
`ifdef MII_PHY_RX_GEN_FCS_EN
      FCS: begin
        dv_next  = 1'b1;
        rxd_next = fcs_word[{fcs_cnt_next, 2'b00} +: 4];
      end
`endif
      UNDER: begin
        if (!drain_next) begin
          dv_next = 1'b1;
          er_next = 1'b1;
          uf_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pre_cnt_reg     <= 4'd0;
      ifg_cnt_reg     <= 8'd0;
      byte_reg        <= 8'h00;
      last_reg        <= 1'b0;
      user_reg        <= 1'b0;
      nib_reg         <= 1'b0;
      drain_reg       <= 1'b0;
      mii_rxd         <= 4'h0;
      mii_rx_dv       <= 1'b0;
      mii_rx_er       <= 1'b0;
      start_packet    <= 1'b0;
      error_underflow <= 1'b0;
`ifdef MII_PHY_RX_GEN_FCS_EN
      crc_reg         <= CRC32_INIT;
      fcs_cnt_reg     <= 3'd0;
`endif
    end else begin
      state_reg       <= state_next;
      pre_cnt_reg     <= pre_cnt_next;
      ifg_cnt_reg     <= ifg_cnt_next;
      byte_reg        <= byte_next;
      last_reg        <= last_next;
      user_reg        <= user_next;
      nib_reg         <= nib_next;
      drain_reg       <= drain_next;
      mii_rxd         <= rxd_next;
      mii_rx_dv       <= dv_next;
      mii_rx_er       <= er_next;
      start_packet    <= sp_next;
      error_underflow <= uf_next;
`ifdef MII_PHY_RX_GEN_FCS_EN
      crc_reg         <= crc_next;
      fcs_cnt_reg     <= fcs_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_mii_phy_rx_gen.sv
// Scoreboard bench for mii_phy_rx_gen: expected nibbles queued by stimulus, checked by a monitor.
module tb_mii_phy_rx_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic       s_axis_tuser;
  logic [3:0] mii_rxd;
  logic       mii_rx_dv;
  logic       mii_rx_er;
  logic       start_packet;
  logic       error_underflow;

  mii_phy_rx_gen #(.PREAMBLE_NIBBLES(15), .IFG_NIBBLES(24)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tuser    (s_axis_tuser),
    .mii_rxd         (mii_rxd),
    .mii_rx_dv       (mii_rx_dv),
    .mii_rx_er       (mii_rx_er),
    .start_packet    (start_packet),
    .error_underflow (error_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] rxd;
    logic       er;
    logic       sp;
    logic       uf;
  } exp_t;

  exp_t       exp_q[$];
  int         gap_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] fd [0:31];
  logic       fu [0:31];

  task automatic push(input logic [3:0] r, input logic er, input logic sp, input logic uf);
    exp_q.push_back({r, er, sp, uf});
  endtask

  // Independent bit-serial reference for the FCS of fd[base +: len].
  function automatic logic [31:0] fcs_of(input int base, input int len);
    logic [31:0] c = 32'hFFFFFFFF;
    logic        b;
    for (int i = 0; i < len; i++) begin
      for (int k = 0; k < 8; k++) begin
        b = c[0] ^ fd[base + i][k];
        c = c >> 1;
        if (b) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic push_exp(input int base, input int len, input int ufl_at, input logic [31:0] fcs);
    push(4'h5, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 15; i++) push(4'h5, 1'b0, 1'b0, 1'b0);
    push(4'hD, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < len; i++) begin
      if (ufl_at >= 0 && i >= ufl_at) break;
      push(fd[base + i][3:0], fu[base + i], 1'b0, 1'b0);
      push(fd[base + i][7:4], fu[base + i], 1'b0, 1'b0);
    end
    if (ufl_at >= 0) begin
      push(4'h0, 1'b1, 1'b0, 1'b1);
    end else begin
`ifdef MII_PHY_RX_GEN_FCS_EN
      for (int k = 0; k < 8; k++) push(fcs[4*k +: 4], 1'b0, 1'b0, 1'b0);
`else
      if (fcs == 32'h0) push(4'h0, 1'b0, 1'b0, 1'b0);
`endif
    end
  endtask

  // Drives fd[base +: len]; at index ufl_at tvalid drops for two cycles first.
  task automatic send_frame(input int base, input int len, input int ufl_at);
    int n;
    for (int i = 0; i < len; i++) begin
      if (i == ufl_at) begin
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
      end
      s_axis_tdata  = fd[base + i];
      s_axis_tuser  = fu[base + i];
      s_axis_tlast  = (i == len - 1);
      s_axis_tvalid = 1'b1;
      n = 0;
      forever begin
        @(negedge clk);
        if (s_axis_tready) break;
        n++;
        if (n > 500) break;
      end
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: byte %0d of frame at %0d never accepted, required tready=1", i, base);
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every nibble with rx_dv=1 is matched against the scoreboard.
  initial begin
    exp_t e;
    int   gap_cnt = 0;
    int   exact;
    logic dv_prev = 1'b0;
    logic seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (mii_rx_dv) begin
          if (!dv_prev && seen) begin
            checks++;
            if (gap_q.size() == 0) begin
              errors++;
              $display("FAIL gap_unexpected: frame start after %0d idle cycles, required no further frame", gap_cnt);
            end else begin
              exact = gap_q.pop_front();
              if (exact != 0 ? (gap_cnt != 24) : (gap_cnt < 24)) begin
                errors++;
                $display("FAIL ifg_gap: got %0d idle cycles, required %s24", gap_cnt, exact != 0 ? "" : ">=");
              end
            end
          end
          seen = 1'b1;
          gap_cnt = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_nibble: rxd=%h er=%b with empty scoreboard", mii_rxd, mii_rx_er);
          end else begin
            e = exp_q.pop_front();
            if ({mii_rxd, mii_rx_er, start_packet, error_underflow} !== e) begin
              errors++;
              $display("FAIL nibble: got rxd=%h er=%b sp=%b uf=%b, required rxd=%h er=%b sp=%b uf=%b",
                       mii_rxd, mii_rx_er, start_packet, error_underflow, e.rxd, e.er, e.sp, e.uf);
            end
          end
        end else begin
          gap_cnt++;
          checks++;
          if ({mii_rx_er, start_packet, error_underflow} !== 3'b000) begin
            errors++;
            $display("FAIL idle_flags: got er=%b sp=%b uf=%b with rx_dv=0, required 000",
                     mii_rx_er, start_packet, error_underflow);
          end
        end
        dv_prev = mii_rx_dv;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h31;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      fd[i] = 8'h00;
      fu[i] = 1'b0;
    end

    // Frame 1: "123456789", held valid through reset.
    for (int i = 0; i < 9; i++) fd[i] = 8'(8'h31 + i);
    push_exp(0, 9, -1, 32'hCBF43926);

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (mii_rx_dv !== 1'b0 || s_axis_tready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: cycle %0d rx_dv=%b tready=%b, required 0 0", c, mii_rx_dv, s_axis_tready);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mii_rx_dv !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_early: rx_dv=%b before first sampling edge, required 0", mii_rx_dv);
    end
    @(negedge clk);
    checks++;
    if (mii_rx_dv !== 1'b1 || mii_rxd !== 4'h5 || start_packet !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_nibble: rx_dv=%b rxd=%h sp=%b, required 1 5 1", mii_rx_dv, mii_rxd, start_packet);
    end
    send_frame(0, 9, -1);
    $display("tx frame1 9 bytes sent");
    s_axis_tvalid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Frame 2: 5 bytes, tuser on byte index 3.
    fd[0] = 8'h10; fd[1] = 8'h21; fd[2] = 8'h32; fd[3] = 8'h43; fd[4] = 8'h54;
    fu[3] = 1'b1;
    gap_q.push_back(0);
    push_exp(0, 5, -1, fcs_of(0, 5));
    send_frame(0, 5, -1);
    $display("tx frame2 5 bytes sent, tuser on byte 3");
    s_axis_tvalid = 1'b0;
    fu[3] = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Frame 3: 6 bytes, tvalid missing at the fetch for byte 2.
    for (int i = 0; i < 6; i++) fd[i] = 8'(8'hA0 + i);
    gap_q.push_back(0);
    push_exp(0, 6, 2, 32'h0);
    send_frame(0, 6, 2);
    $display("tx frame3 6 bytes sent, underflow at byte 2");
    s_axis_tvalid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Frames 4 and 5 back to back; frame 5 is a single byte.
    fd[0] = 8'hC1; fd[1] = 8'hC2; fd[2] = 8'hC3; fd[3] = 8'h7E;
    gap_q.push_back(0);
    push_exp(0, 3, -1, fcs_of(0, 3));
    gap_q.push_back(1);
    push_exp(3, 1, -1, fcs_of(3, 1));
    send_frame(0, 3, -1);
    $display("tx frame4 3 bytes sent");
    send_frame(3, 1, -1);
    $display("tx frame5 1 byte sent back to back");
    s_axis_tvalid = 1'b0;

    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d expected nibbles never seen, required 0", exp_q.size());
    end
    repeat (40) @(posedge clk);
    checks++;
    if (gap_q.size() != 0) begin
      errors++;
      $display("FAIL missing_frames: %0d frame starts never seen, required 0", gap_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
